// File: rtl/n64adv_vparams.sv
// Vertical scaler parameters shared by the config generator and the line sequencer:
// sequencer FSM encoding, weight width and the Q17 fixed-point format.
package n64adv_vparams;

    typedef enum logic [2:0] {
        VST_IDLE  = 3'd0,
        VST_LOAD0 = 3'd1,
        VST_LOAD1 = 3'd2,
        VST_RUN   = 3'd3,
        VST_DONE  = 3'd4
    } vseq_state_e;

    localparam int V_WEIGHT_W = 8;
    localparam int Q17_FRAC   = 17;
    localparam int VLINE_W    = 10;
    localparam int VOUT_W     = 11;
    localparam int VFACTOR_W  = 18;

endpackage

// File: rtl/scaler_vline_seq.sv
// Vertical read-side sequencer: turns output line requests into two line-buffer
// read indices plus the interpolation weight of the lower line.
module scaler_vline_seq
    import n64adv_vparams::*;
#(
    parameter int WEIGHT_W = V_WEIGHT_W,
    parameter int ACC_W    = 28
) (
    input  logic                 SYS_CLK,
    input  logic                 nRST,
    input  logic                 frame_start_i,
    input  logic [VLINE_W-1:0]   vpos_1st_rdline_i,
    input  logic [VLINE_W-1:0]   vlines_in_needed_i,
    input  logic [VOUT_W-1:0]    vlines_out_i,
    input  logic [VFACTOR_W-1:0] v_interp_factor_i,
    input  logic                 line_req_i,
    output logic                 ready_o,
    output logic                 line_valid_o,
    output logic [VLINE_W-1:0]   rdline_a_o,
    output logic [VLINE_W-1:0]   rdline_b_o,
    output logic [WEIGHT_W-1:0]  v_weight_o,
    output logic [VOUT_W-1:0]    out_line_cnt_o,
    output logic                 frame_done_o
);

    localparam int IPOS_W = ACC_W - Q17_FRAC;

    vseq_state_e state_q, state_d;

    logic [VLINE_W-1:0]   vpos_q, vpos_d;
    logic [VLINE_W-1:0]   needed_q, needed_d;
    logic [VOUT_W-1:0]    vout_q, vout_d;
    logic [VFACTOR_W-1:0] factor_q, factor_d;
    logic [ACC_W-1:0]     step_q, step_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [VOUT_W-1:0]    cnt_q, cnt_d;

    logic                 line_valid_q, line_valid_d;
    logic [VLINE_W-1:0]   rdline_a_q, rdline_a_d;
    logic [VLINE_W-1:0]   rdline_b_q, rdline_b_d;
    logic [WEIGHT_W-1:0]  weight_q, weight_d;
    logic [VOUT_W-1:0]    out_cnt_q, out_cnt_d;
    logic                 done_pend_q, done_pend_d;
    logic                 frame_done_q, frame_done_d;

    (* multstyle = "dsp" *) logic [ACC_W-1:0] step_prod;
    assign step_prod = ACC_W'(needed_q) * ACC_W'(factor_q);

    logic [IPOS_W-1:0] ipos, ipos_p1, lim, sel_a, sel_b;
    logic              at_bottom, degenerate, last_line;

    always_comb begin
        ipos       = acc_q[ACC_W-1:Q17_FRAC];
        ipos_p1    = ipos + IPOS_W'(1);
        lim        = IPOS_W'(needed_q) - IPOS_W'(1);
        at_bottom  = (ipos >= lim);
        sel_a      = at_bottom ? lim : ipos;
        sel_b      = (ipos_p1 >= lim) ? lim : ipos_p1;
        degenerate = (needed_q == '0) || (vout_q == '0);
        last_line  = ((cnt_q + VOUT_W'(1)) == vout_q);
    end

    always_ff @(posedge SYS_CLK or negedge nRST) begin
        if (!nRST) state_q <= VST_IDLE;
        else       state_q <= state_d;
    end

    // A new frame start always wins, aborting whatever frame is in flight.
    always_comb begin
        state_d = state_q;
        if (frame_start_i) begin
            state_d = VST_LOAD0;
        end else begin
            case (state_q)
                VST_LOAD0: state_d = VST_LOAD1;
                VST_LOAD1: state_d = degenerate ? VST_DONE : VST_RUN;
                VST_RUN:   if (line_req_i && last_line) state_d = VST_DONE;
                default:   ;
            endcase
        end
    end

    always_comb begin
        ready_o = (state_q == VST_RUN);
    end

    always_comb begin
        vpos_d       = vpos_q;
        needed_d     = needed_q;
        vout_d       = vout_q;
        factor_d     = factor_q;
        step_d       = step_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        line_valid_d = 1'b0;
        rdline_a_d   = rdline_a_q;
        rdline_b_d   = rdline_b_q;
        weight_d     = weight_q;
        out_cnt_d    = out_cnt_q;
        done_pend_d  = 1'b0;
        frame_done_d = done_pend_q;
        if (frame_start_i) begin
            vpos_d   = vpos_1st_rdline_i;
            needed_d = vlines_in_needed_i;
            vout_d   = vlines_out_i;
            factor_d = v_interp_factor_i;
        end else begin
            case (state_q)
                VST_LOAD0: step_d = step_prod;
                VST_LOAD1: begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (degenerate) frame_done_d = 1'b1;
                end
                VST_RUN: if (line_req_i) begin
                    line_valid_d = 1'b1;
                    rdline_a_d   = VLINE_W'(IPOS_W'(vpos_q) + sel_a);
                    rdline_b_d   = VLINE_W'(IPOS_W'(vpos_q) + sel_b);
                    // Past the last needed line both taps sit on it, so blending is off.
                    weight_d     = at_bottom ? '0 : acc_q[Q17_FRAC-1 -: WEIGHT_W];
                    out_cnt_d    = cnt_q;
                    acc_d        = acc_q + step_q;
                    cnt_d        = cnt_q + VOUT_W'(1);
                    done_pend_d  = last_line;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK or negedge nRST) begin
        if (!nRST) begin
            vpos_q       <= '0;
            needed_q     <= '0;
            vout_q       <= '0;
            factor_q     <= '0;
            step_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            line_valid_q <= 1'b0;
            rdline_a_q   <= '0;
            rdline_b_q   <= '0;
            weight_q     <= '0;
            out_cnt_q    <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            vpos_q       <= vpos_d;
            needed_q     <= needed_d;
            vout_q       <= vout_d;
            factor_q     <= factor_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            line_valid_q <= line_valid_d;
            rdline_a_q   <= rdline_a_d;
            rdline_b_q   <= rdline_b_d;
            weight_q     <= weight_d;
            out_cnt_q    <= out_cnt_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign line_valid_o   = line_valid_q;
    assign rdline_a_o     = rdline_a_q;
    assign rdline_b_o     = rdline_b_q;
    assign v_weight_o     = weight_q;
    assign out_line_cnt_o = out_cnt_q;
    assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_scaler_vline_seq.sv
// Bench for scaler_vline_seq: scenario tasks checked against an arithmetic
// model of output-line position (k * needed * factor in Q17).
module tb_scaler_vline_seq;

    typedef struct {
        int vpos;
        int needed;
        int nout;
        int factor;
    } cfg_t;

    logic        SYS_CLK;
    logic        nRST;
    logic        frame_start_i;
    logic [9:0]  vpos_1st_rdline_i;
    logic [9:0]  vlines_in_needed_i;
    logic [10:0] vlines_out_i;
    logic [17:0] v_interp_factor_i;
    logic        line_req_i;
    logic        ready_o;
    logic        line_valid_o;
    logic [9:0]  rdline_a_o;
    logic [9:0]  rdline_b_o;
    logic [7:0]  v_weight_o;
    logic [10:0] out_line_cnt_o;
    logic        frame_done_o;

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;
    int obs_a[4];
    int obs_b[4];
    int obs_w[4];

    scaler_vline_seq dut (
        .SYS_CLK            (SYS_CLK),
        .nRST               (nRST),
        .frame_start_i      (frame_start_i),
        .vpos_1st_rdline_i  (vpos_1st_rdline_i),
        .vlines_in_needed_i (vlines_in_needed_i),
        .vlines_out_i       (vlines_out_i),
        .v_interp_factor_i  (v_interp_factor_i),
        .line_req_i         (line_req_i),
        .ready_o            (ready_o),
        .line_valid_o       (line_valid_o),
        .rdline_a_o         (rdline_a_o),
        .rdline_b_o         (rdline_b_o),
        .v_weight_o         (v_weight_o),
        .out_line_cnt_o     (out_line_cnt_o),
        .frame_done_o       (frame_done_o)
    );

    initial begin
        SYS_CLK = 1'b0;
        forever #5 SYS_CLK = ~SYS_CLK;
    end

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    // Output line k sits at input position k*needed/out lines, i.e. k*needed*factor in Q17.
    function automatic void model(input cfg_t c, input int k, output int a, output int b, output int w);
        longint p, ip, lim, sa, sb;
        p   = longint'(k) * longint'(c.needed) * longint'(c.factor);
        ip  = p / 131072;
        lim = longint'(c.needed) - 1;
        sa  = (ip < lim) ? ip : lim;
        sb  = (ip + 1 < lim) ? ip + 1 : lim;
        a   = int'((longint'(c.vpos) + sa) % 1024);
        b   = int'((longint'(c.vpos) + sb) % 1024);
        w   = (ip >= lim) ? 0 : int'((p / 512) % 256);
    endfunction

    task automatic drive_cfg(input cfg_t c);
        vpos_1st_rdline_i  = 10'(c.vpos);
        vlines_in_needed_i = 10'(c.needed);
        vlines_out_i       = 11'(c.nout);
        v_interp_factor_i  = 18'(c.factor);
    endtask

    task automatic start_frame(input cfg_t c);
        frame_start_i = 1'b1;
        drive_cfg(c);
        tick();
        frame_start_i = 1'b0;
        vpos_1st_rdline_i  = 10'($urandom);
        vlines_in_needed_i = 10'($urandom);
        vlines_out_i       = 11'($urandom);
        v_interp_factor_i  = 18'($urandom);
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL start_ready_t1 got %0b want 0", ready_o); end
        checks++;
        if (frame_done_o !== 1'b0) begin errors++; $display("FAIL start_done_t1 got %0b want 0", frame_done_o); end
        tick();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL start_ready_t2 got %0b want 0", ready_o); end
        checks++;
        if (frame_done_o !== 1'b0) begin errors++; $display("FAIL start_done_t2 got %0b want 0", frame_done_o); end
        tick();
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL start_ready_t3 got %0b want 1", ready_o); end
        checks++;
        if (frame_done_o !== 1'b0) begin errors++; $display("FAIL start_done_t3 got %0b want 0", frame_done_o); end
        cur_k = 0;
    endtask

    task automatic do_requests(input cfg_t c, input int n, input bit b2b);
        int g, ea, eb, ew;
        bit last;
        for (int i = 0; i < n; i++) begin
            if (!b2b) begin
                g = int'($urandom_range(0, 2));
                for (int j = 0; j < g; j++) begin
                    tick();
                    checks++;
                    if (line_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b want 0", line_valid_o); end
                end
            end
            line_req_i = 1'b1;
            tick();
            line_req_i = 1'b0;
            model(c, cur_k, ea, eb, ew);
            last = (cur_k == c.nout - 1);
            $display("resp k=%0d a=%0d b=%0d w=%0d cnt=%0d", cur_k, rdline_a_o, rdline_b_o, v_weight_o, out_line_cnt_o);
            checks++;
            if (line_valid_o !== 1'b1) begin errors++; $display("FAIL resp_valid k=%0d got %0b want 1", cur_k, line_valid_o); end
            checks++;
            if (rdline_a_o !== 10'(ea)) begin errors++; $display("FAIL resp_a k=%0d got %0d want %0d", cur_k, rdline_a_o, ea); end
            checks++;
            if (rdline_b_o !== 10'(eb)) begin errors++; $display("FAIL resp_b k=%0d got %0d want %0d", cur_k, rdline_b_o, eb); end
            checks++;
            if (v_weight_o !== 8'(ew)) begin errors++; $display("FAIL resp_w k=%0d got %0d want %0d", cur_k, v_weight_o, ew); end
            checks++;
            if (out_line_cnt_o !== 11'(cur_k)) begin errors++; $display("FAIL resp_cnt got %0d want %0d", out_line_cnt_o, cur_k); end
            checks++;
            if (ready_o !== !last) begin errors++; $display("FAIL resp_ready k=%0d got %0b want %0b", cur_k, ready_o, !last); end
            checks++;
            if (frame_done_o !== 1'b0) begin errors++; $display("FAIL resp_done_early k=%0d got %0b want 0", cur_k, frame_done_o); end
            if (cur_k < 4) begin
                obs_a[cur_k] = int'(rdline_a_o);
                obs_b[cur_k] = int'(rdline_b_o);
                obs_w[cur_k] = int'(v_weight_o);
            end
            cur_k++;
        end
    endtask

    task automatic finish_frame();
        line_req_i = 1'b0;
        tick();
        checks++;
        if (frame_done_o !== 1'b1) begin errors++; $display("FAIL done_pulse got %0b want 1", frame_done_o); end
        checks++;
        if (line_valid_o !== 1'b0) begin errors++; $display("FAIL done_valid got %0b want 0", line_valid_o); end
        line_req_i = 1'b1;
        tick();
        checks++;
        if (frame_done_o !== 1'b0) begin errors++; $display("FAIL done_single got %0b want 0", frame_done_o); end
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL done_ready got %0b want 0", ready_o); end
        tick();
        line_req_i = 1'b0;
        checks++;
        if (line_valid_o !== 1'b0) begin errors++; $display("FAIL done_req_ignored got %0b want 0", line_valid_o); end
    endtask

    task automatic test_reset();
        nRST = 1'b1;
        frame_start_i = 1'b0;
        line_req_i = 1'b0;
        drive_cfg('{0, 0, 0, 0});
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready_o); end
        checks++;
        if (line_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", line_valid_o); end
        checks++;
        if (rdline_a_o !== 10'd0 || rdline_b_o !== 10'd0) begin errors++; $display("FAIL reset_lines got %0d/%0d want 0/0", rdline_a_o, rdline_b_o); end
        checks++;
        if (v_weight_o !== 8'd0 || out_line_cnt_o !== 11'd0) begin errors++; $display("FAIL reset_wcnt got %0d/%0d want 0/0", v_weight_o, out_line_cnt_o); end
        checks++;
        if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", frame_done_o); end
        repeat (2) @(posedge SYS_CLK);
        #4 nRST = 1'b1;
        tick();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready got %0b want 0", ready_o); end
    endtask

    task automatic test_upscale_2x();
        cfg_t c;
        int ta[4] = '{0, 0, 0, 1};
        int tb[4] = '{1, 1, 1, 2};
        int tw[4] = '{0, 127, 255, 127};
        c = '{0, 240, 480, 273};
        start_frame(c);
        do_requests(c, c.nout, 1'b1);
        finish_frame();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_a[i] != ta[i] || obs_b[i] != tb[i] || obs_w[i] != tw[i]) begin
                errors++;
                $display("FAIL up2x_table k=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, obs_a[i], obs_b[i], obs_w[i], ta[i], tb[i], tw[i]);
            end
        end
    endtask

    task automatic test_one_to_one();
        cfg_t c;
        c = '{24, 240, 240, 546};
        start_frame(c);
        do_requests(c, c.nout, 1'b0);
        finish_frame();
        checks++;
        if (obs_a[1] != 24 || obs_b[1] != 25 || obs_w[1] != 255) begin
            errors++;
            $display("FAIL one2one_resp1 got (%0d,%0d,%0d) want (24,25,255)", obs_a[1], obs_b[1], obs_w[1]);
        end
    endtask

    // 1.5 input lines per output line: fractional weights reach the clamp and the 10-bit wrap.
    task automatic test_bottom_clamp();
        cfg_t c;
        c = '{1021, 4, 8, 49152};
        start_frame(c);
        do_requests(c, c.nout, 1'b1);
        finish_frame();
    endtask

    task automatic test_random_frames();
        cfg_t c;
        for (int f = 0; f < 6; f++) begin
            c.vpos   = int'($urandom_range(0, 1023));
            c.needed = int'($urandom_range(1, 1023));
            c.nout   = int'($urandom_range(1, 40));
            c.factor = 131072 / c.nout;
            start_frame(c);
            do_requests(c, c.nout, f[0]);
            finish_frame();
        end
    endtask

    task automatic test_abort();
        cfg_t ca, cb;
        ca = '{0, 240, 480, 273};
        cb = '{10, 100, 50, 2621};
        start_frame(ca);
        do_requests(ca, 100, 1'b1);
        start_frame(cb);
        do_requests(cb, cb.nout, 1'b0);
        finish_frame();
    endtask

    task automatic test_simultaneous();
        cfg_t cc, cd;
        cc = '{7, 50, 20, 6553};
        cd = '{2, 30, 10, 13107};
        start_frame(cc);
        do_requests(cc, 3, 1'b1);
        frame_start_i = 1'b1;
        drive_cfg(cd);
        line_req_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        checks++;
        if (line_valid_o !== 1'b0) begin errors++; $display("FAIL simul_valid got %0b want 0", line_valid_o); end
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL simul_load0_ready got %0b want 0", ready_o); end
        tick();
        checks++;
        if (line_valid_o !== 1'b0) begin errors++; $display("FAIL load0_req_valid got %0b want 0", line_valid_o); end
        tick();
        line_req_i = 1'b0;
        checks++;
        if (line_valid_o !== 1'b0) begin errors++; $display("FAIL load1_req_valid got %0b want 0", line_valid_o); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL simul_run_ready got %0b want 1", ready_o); end
        cur_k = 0;
        do_requests(cd, cd.nout, 1'b0);
        finish_frame();
    endtask

    task automatic test_degenerate();
        cfg_t d[2];
        d[0] = '{3, 100, 0, 0};
        d[1] = '{3, 0, 5, 100};
        for (int i = 0; i < 2; i++) begin
            frame_start_i = 1'b1;
            drive_cfg(d[i]);
            tick();
            frame_start_i = 1'b0;
            line_req_i = 1'b1;
            for (int t = 1; t <= 4; t++) begin
                checks++;
                if (frame_done_o !== (t == 3)) begin errors++; $display("FAIL degen%0d_done t+%0d got %0b want %0b", i, t, frame_done_o, t == 3); end
                checks++;
                if (line_valid_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL degen%0d_resp t+%0d got v%0b r%0b want v0 r0", i, t, line_valid_o, ready_o); end
                tick();
            end
            line_req_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        cfg_t c;
        c = '{100, 200, 60, 2184};
        start_frame(c);
        do_requests(c, 10, 1'b1);
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (line_valid_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ctl got v%0b r%0b want v0 r0", line_valid_o, ready_o); end
        checks++;
        if (rdline_a_o !== 10'd0 || rdline_b_o !== 10'd0) begin errors++; $display("FAIL midrst_lines got %0d/%0d want 0/0", rdline_a_o, rdline_b_o); end
        checks++;
        if (v_weight_o !== 8'd0 || out_line_cnt_o !== 11'd0 || frame_done_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_misc got w%0d c%0d d%0b want 0", v_weight_o, out_line_cnt_o, frame_done_o);
        end
        #10 nRST = 1'b1;
        tick();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL midrst_idle_ready got %0b want 0", ready_o); end
        line_req_i = 1'b1;
        tick();
        line_req_i = 1'b0;
        checks++;
        if (line_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_idle_req got %0b want 0", line_valid_o); end
    endtask

    initial begin
        test_reset();
        test_upscale_2x();
        test_one_to_one();
        test_bottom_clamp();
        test_random_frames();
        test_abort();
        test_simultaneous();
        test_degenerate();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
